// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller. It accepts a block, applies the initial AddRoundKey,
// steps an external combinational round datapath through NR rounds, then offers the result.
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [128*(NR+1)-1:0]   expanded_key,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            in_data,
    input  logic                    in_mode,
    output logic [127:0]            rnd_state,
    output logic [127:0]            rnd_key,
    output logic                    rnd_last,
    output logic                    rnd_inv,
    input  logic [127:0]            rnd_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        blk_count
);

    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LAST_RND = RW'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [127:0]     state_reg_q, state_reg_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] blk_count_q, blk_count_d;
    logic             accept;
    logic [127:0]     init_key;

    // Decryption walks the key schedule backwards, so round r uses slice NR-r.
    function automatic logic [127:0] key_slice(input logic [128*(NR+1)-1:0] ek,
                                               input logic [RW-1:0]         r,
                                               input logic                  inv);
        logic [RW-1:0] idx;
        idx = inv ? (LAST_RND - r) : r;
        return ek[int'(idx)*128 +: 128];
    endfunction

    always_comb begin
        in_ready = key_valid & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
        accept   = in_valid & in_ready;
        // The whitening key follows the incoming mode, not the latched one.
        init_key = key_slice(expanded_key, '0, in_mode);
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_reg_d = state_reg_q;
        rcnt_d      = rcnt_q;
        mode_d      = mode_q;
        blk_count_d = blk_count_q;

        case (fsm_q)
            IDLE: begin
                fsm_d = IDLE;
            end
            ROUND: begin
                state_reg_d = rnd_result;
                if (rcnt_q == LAST_RND) begin
                    fsm_d = DONE;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    blk_count_d = blk_count_q + CNT_W'(1);
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // Acceptance overrides the DONE->IDLE exit so back-to-back blocks skip the idle bubble.
        if (accept) begin
            mode_d      = in_mode;
            state_reg_d = in_data ^ init_key;
            rcnt_d      = RW'(1);
            fsm_d       = ROUND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_reg_q <= '0;
            rcnt_q      <= '0;
            mode_q      <= 1'b0;
            blk_count_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_reg_q <= state_reg_d;
            rcnt_q      <= rcnt_d;
            mode_q      <= mode_d;
            blk_count_q <= blk_count_d;
        end
    end

    always_comb begin
        rnd_state = state_reg_q;
        rnd_inv   = mode_q;
        rnd_key   = key_slice(expanded_key, '0, mode_q);
        rnd_last  = 1'b0;
        if (fsm_q == ROUND) begin
            rnd_key  = key_slice(expanded_key, rcnt_q, mode_q);
            rnd_last = (rcnt_q == LAST_RND);
        end
        out_valid = (fsm_q == DONE);
        out_data  = state_reg_q;
        busy      = (fsm_q != IDLE);
        blk_count = blk_count_q;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round datapath
// and FIPS-197 C.1 vectors; the counter is narrowed so its wrap is reachable quickly.
module tb_aes_round_sequencer;

    localparam int NR    = 10;
    localparam int CNT_W = 8;

    localparam logic [127:0] CIPHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT         = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT         = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  key_valid;
    logic [128*(NR+1)-1:0] ek;
    logic                  in_valid;
    logic                  in_ready;
    logic [127:0]          in_data;
    logic                  in_mode;
    logic [127:0]          rnd_state;
    logic [127:0]          rnd_key;
    logic                  rnd_last;
    logic                  rnd_inv;
    logic [127:0]          rnd_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [127:0]          out_data;
    logic                  busy;
    logic [CNT_W-1:0]      blk_count;

    logic                  use_stub;
    logic [7:0]            sbox_t [256];
    logic [7:0]            inv_t  [256];
    logic [CNT_W-1:0]      exp_count;
    int                    n_cmp  = 0;
    int                    n_fail = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(NR), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .expanded_key (ek),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .rnd_state    (rnd_state),
        .rnd_key      (rnd_key),
        .rnd_last     (rnd_last),
        .rnd_inv      (rnd_inv),
        .rnd_result   (rnd_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .blk_count    (blk_count)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Byte n of a block sits at bits [127-8n -: 8]; row = n%4, column = n/4.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last, input logic inv);
        logic [7:0]   s [16];
        logic [127:0] t;
        for (int n = 0; n < 16; n++) s[n] = st[127-8*n -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!inv) t[127-8*(r+4*c) -: 8] = sbox_t[s[r+4*((c+r)%4)]];
                else      t[127-8*(r+4*c) -: 8] = inv_t[s[r+4*((c-r+4)%4)]] ^ key[127-8*(r+4*c) -: 8];
            end
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                if (!inv) t[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
                else      t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
            end
        end
        return inv ? t : (t ^ key);
    endfunction

    assign rnd_result = use_stub ? rnd_state : aes_round(rnd_state, rnd_key, rnd_last, rnd_inv);

    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic m);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Offers one block, follows every round's key/last flag, and returns at the first out_valid.
    task automatic runBlock(input logic [127:0] data, input logic mode, input int drop_kv_at,
                            output logic [127:0] result, output int lat);
        int k;
        logic [127:0] exp_key;
        applyStimulus(1'b1, data, mode);
        #1;
        checkOutput("accept_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 128'h0, 1'b0);
        checkOutput("busy_after_accept", 128'(busy), 128'(1'b1));
        checkOutput("no_valid_after_accept", 128'(out_valid), 128'(1'b0));
        lat = 0;
        k   = 1;
        while (!out_valid && lat < 30) begin
            if (k <= NR) begin
                exp_key = mode ? ek[128*(NR-k) +: 128] : ek[128*k +: 128];
                checkOutput($sformatf("rnd_key_%0d", k), rnd_key, exp_key);
                checkOutput($sformatf("rnd_last_%0d", k), 128'(rnd_last), 128'(k == NR));
            end
            if (k == drop_kv_at) key_valid = 1'b0;
            k++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        result = out_data;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc, inv_b, s;
        logic [127:0] res;
        int           lat, cyc;

        // Build S-box tables from the GF(2^8) inverse plus affine map.
        for (int x = 0; x < 256; x++) begin
            inv_b = 8'h01;
            for (int i = 0; i < 254; i++) inv_b = gmul(inv_b, 8'(x));
            if (x == 0) inv_b = 8'h00;
            s = inv_b ^ {inv_b[6:0], inv_b[7]} ^ {inv_b[5:0], inv_b[7:6]} ^
                {inv_b[4:0], inv_b[7:5]} ^ {inv_b[3:0], inv_b[7:4]} ^ 8'h63;
            sbox_t[x] = s;
            inv_t[s]  = 8'(x);
        end

        for (int i = 0; i < 4; i++) w[i] = CIPHER_KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        use_stub  = 1'b0;
        rst       = 1'b1;
        key_valid = 1'b0;
        out_ready = 1'b0;
        exp_count = '0;
        applyStimulus(1'b0, 128'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 128'(busy), 128'(1'b0));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("rst_blk_count", 128'(blk_count), 128'(0));
        checkOutput("rst_rnd_state", rnd_state, 128'h0);
        checkOutput("rst_rnd_last", 128'(rnd_last), 128'(1'b0));
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1'b0));
        rst = 1'b0;

        // key_valid low blocks acceptance even with a block on offer
        applyStimulus(1'b1, PT, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("kv_gate_ready", 128'(in_ready), 128'(1'b0));
            checkOutput("kv_gate_busy", 128'(busy), 128'(1'b0));
        end
        key_valid = 1'b1;
        #1;
        checkOutput("kv_ready", 128'(in_ready), 128'(1'b1));

        $display("[TB] encrypt C.1");
        out_ready = 1'b1;
        runBlock(PT, 1'b0, 0, res, lat);
        checkOutput("enc_latency", 128'(lat), 128'(10));
        checkOutput("enc_data", res, CT);
        @(posedge clk);
        exp_count++;
        @(negedge clk);
        checkOutput("enc_blk_count", 128'(blk_count), 128'(exp_count));
        checkOutput("enc_idle", 128'(busy), 128'(1'b0));

        $display("[TB] decrypt C.1");
        runBlock(CT, 1'b1, 0, res, lat);
        checkOutput("dec_latency", 128'(lat), 128'(10));
        checkOutput("dec_data", res, PT);
        checkOutput("dec_inv", 128'(rnd_inv), 128'(1'b1));
        @(posedge clk);
        exp_count++;
        @(negedge clk);
        checkOutput("dec_blk_count", 128'(blk_count), 128'(exp_count));

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        runBlock(PT, 1'b0, 0, res, lat);
        checkOutput("bp_data", res, CT);
        applyStimulus(1'b1, CT, 1'b1);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_valid_held", 128'(out_valid), 128'(1'b1));
            checkOutput("bp_data_stable", out_data, CT);
            checkOutput("bp_in_ready", 128'(in_ready), 128'(1'b0));
            checkOutput("bp_count_held", 128'(blk_count), 128'(exp_count));
        end
        out_ready = 1'b1;
        exp_count++;
        runBlock(CT, 1'b1, 0, res, lat);
        checkOutput("b2b_latency", 128'(lat), 128'(10));
        checkOutput("b2b_data", res, PT);
        checkOutput("b2b_blk_count", 128'(blk_count), 128'(exp_count));
        @(posedge clk);
        exp_count++;
        @(negedge clk);
        checkOutput("b2b_idle", 128'(busy), 128'(1'b0));

        $display("[TB] reset mid-block");
        applyStimulus(1'b1, CT, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 128'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rst_busy", 128'(busy), 128'(1'b0));
        checkOutput("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("mid_rst_count", 128'(blk_count), 128'(0));
        checkOutput("mid_rst_state", rnd_state, 128'h0);
        checkOutput("mid_rst_inv", 128'(rnd_inv), 128'(1'b0));
        checkOutput("mid_rst_last", 128'(rnd_last), 128'(1'b0));
        checkOutput("mid_rst_ready", 128'(in_ready), 128'(1'b1));
        rst       = 1'b0;
        exp_count = '0;
        runBlock(PT, 1'b0, 0, res, lat);
        checkOutput("post_rst_data", res, CT);
        checkOutput("post_rst_latency", 128'(lat), 128'(10));
        @(posedge clk);
        exp_count++;
        @(negedge clk);
        checkOutput("post_rst_count", 128'(blk_count), 128'(exp_count));

        $display("[TB] key_valid drop mid-block");
        runBlock(PT, 1'b0, 3, res, lat);
        checkOutput("kv_drop_data", res, CT);
        checkOutput("kv_drop_latency", 128'(lat), 128'(10));
        checkOutput("kv_drop_ready", 128'(in_ready), 128'(1'b0));
        @(posedge clk);
        exp_count++;
        @(negedge clk);
        checkOutput("kv_drop_count", 128'(blk_count), 128'(exp_count));
        checkOutput("kv_drop_idle", 128'(busy), 128'(1'b0));
        key_valid = 1'b1;

        $display("[TB] counter wrap with identity round");
        use_stub = 1'b1;
        applyStimulus(1'b1, PT, 1'b0);
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (exp_count == {CNT_W{1'b1}}) break;
                exp_count++;
            end
        end
        checkOutput("wrap_in_budget", 128'(cyc < 4000), 128'(1'b1));
        checkOutput("wrap_pre_count", 128'(blk_count), 128'({CNT_W{1'b1}}));
        checkOutput("stub_data", out_data, PT ^ ek[127:0]);
        applyStimulus(1'b0, 128'h0, 1'b0);
        @(posedge clk);
        exp_count++;
        @(negedge clk);
        checkOutput("wrap_count", 128'(blk_count), 128'(0));
        checkOutput("wrap_exp_count", 128'(blk_count), 128'(exp_count));
        checkOutput("wrap_idle", 128'(busy), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
